lcd_text_driver: RTL and testbench
==================================

# lcd_text_driver

- Parametrised HD44780-compatible character-LCD driver: power-up init sequence, then full-frame writes of an ROWS×COLS text buffer over the 8-bit parallel bus.
- Successor to the fixed 2×16 free-running LCD writer. Adds:
  - configurable geometry;
  - an internal EN-rate prescaler, so it runs from the system clock;
  - a request/acknowledge update handshake with frame snapshot;
  - an optional free-running refresh mode;
  - asynchronous reset.
- Sits between application logic (text formatting) and the board LCD pins.

## Interface
Parameters:
- ROWS, 2: display rows, 1..4.
- COLS, 16: characters per row, 8..40.
- TICK_DIV, 125000: clk cycles per bus tick. 50 MHz / 125000 = 400 Hz.
- PWRUP_TICKS, 20: ticks waited after reset before the first command.
- CLEAR_TICKS, 2: extra idle ticks after the 0x01 clear command.
- AUTO_REFRESH, 0: 1 = rewrite frames continuously without requests.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- line_data  in  ROWS*COLS*8  text buffer. Row r, column c is byte [(ROWS*COLS-1-(r*COLS+c))*8 +: 8], i.e. MSB-first, row 0 first.
- update_req  in  1  level request to write one frame.
- update_ack  out  1  one-clk pulse when a request is accepted.
- busy  out  1  high during init and while a frame is being written.
- backlight  in  1  registered onto LCD_BLON.
- LCD_DATA  inout  8  bus. Driven whenever LCD_RW=0, which is always.
- LCD_RW  out  1  constant 0 (write only, no busy-flag polling).
- LCD_EN  out  1  enable strobe.
- LCD_RS  out  1  0 = command, 1 = character.
- LCD_ON  out  1  constant 1.
- LCD_BLON  out  1  backlight.

## Operation
- Tick: one-clk strobe every TICK_DIV clocks from a free-running counter. All bus activity advances only on ticks.
- Write cycle, 3 ticks: T0 drive RS/data with EN=0; T1 EN=1; T2 EN=0 with data held. The next write may start at the following tick.
- FSM states: PWRUP, INIT, CLR_WAIT, IDLE, ADDR, CHAR.
- PWRUP → INIT after PWRUP_TICKS ticks.
- INIT writes commands 0x38, 0x38, 0x38, 0x38, 0x08, 0x01, 0x06, 0x0C, all with RS=0. CLR_WAIT inserts CLEAR_TICKS idle ticks after 0x01.
- After 0x0C → IDLE, busy=0.
- Accept in IDLE when update_req=1:
  - pulse update_ack;
  - snapshot line_data into the frame register;
  - busy=1;
  - row=0, go to ADDR.
- update_req seen while busy is not dropped. Because it is a level, it is accepted at the next IDLE.
- AUTO_REFRESH=1: IDLE immediately takes a snapshot and starts a frame with no update_ack pulse. update_req is ignored.
- ADDR writes 0x80 | base(row), RS=0. Row bases: 0x00, 0x40, 0x14, 0x54. Then go to CHAR with col=0.
- CHAR writes snapshot byte (row, col), RS=1.
  - col < COLS-1: col+1.
  - col = COLS-1 and row < ROWS-1: row+1, go to ADDR.
  - Last character: → IDLE, busy=0.
- line_data changes after the snapshot have no effect on the current frame.

## Timing
- Reset values: LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, LCD_BLON=0, busy=1, update_ack=0, tick counter=0, FSM=PWRUP.
- rst_n low mid-write: EN drops asynchronously. The whole init sequence reruns after release.
- Frame length = ROWS*(COLS+1)*3 ticks. Default 2×16: 102 ticks.
- Init length = (PWRUP_TICKS + 8*3 + CLEAR_TICKS) ticks, with ±1 tick of alignment.
- update_ack latency: the clk after update_req is sampled high in IDLE. busy rises in the same cycle.
- busy falls on the clk of the final T2 tick. A held request is accepted on the next clk, so no idle tick is lost.
- Width rules:
  - row counter is 2 bits;
  - col counter is $clog2(COLS) bits;
  - tick counter is $clog2(TICK_DIV) bits and wraps to 0 at TICK_DIV-1.

## Structure
- Shared package lcd_pkg holds:
  - command constants (FUNC_8BIT_2L=0x38, DISP_OFF=0x08, CLEAR=0x01, ENTRY_INC=0x06, DISP_ON=0x0C, SET_DDRAM=0x80);
  - the row base address array;
  - the FSM state enum.
- Sub-module lcd_bus_writer contains the prescaler and the 3-tick EN cycle.
  - Handshake: start/byte/rs in, done out.
  - The top FSM only sequences bytes.

## Test plan
Bench parameters: TICK_DIV=4, PWRUP_TICKS=2, CLEAR_TICKS=2.
- Release reset → bytes latched on EN falling edge are 38,38,38,38,08,01,06,0C, all RS=0. busy=0 afterwards; no further EN pulses in IDLE.
- ROWS=2, COLS=16; line_data = "HELLO WORLD     " / "0123456789ABCDEF"; pulse update_req → update_ack is exactly 1 clk. Bus sequence: 0x80, then 16 chars with RS=1, then 0xC0, then 16 chars. busy low after 102 ticks.
- ROWS=4, COLS=20 → address bytes 0x80, 0xC0, 0x94, 0xD4, each followed by 20 characters.
- Change line_data to all 0x2A one tick after ack → displayed frame still matches the original snapshot. A second request held high during the frame is acked at the first IDLE clk.
- Assert rst_n low during the 5th character's EN-high tick → EN=0 in the same clk. After release, the full init sequence reappears.
- AUTO_REFRESH=1 → back-to-back frames with no idle tick and update_ack never high. busy stays 1 after init.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and the init command table for the
// HD44780-compatible text driver and its bus writer.
package lcd_pkg;

  localparam logic [7:0] FUNC_8BIT_2L = 8'h38;
  localparam logic [7:0] DISP_OFF     = 8'h08;
  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] ENTRY_INC    = 8'h06;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] SET_DDRAM    = 8'h80;

  // DDRAM base address of each display row, indexed by row number
  localparam logic [3:0][7:0] ROW_BASE = {8'h54, 8'h14, 8'h40, 8'h00};

  localparam int INIT_LEN  = 8;
  localparam int CLEAR_IDX = 5;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    CLR_WAIT,
    IDLE,
    ADDR,
    CHAR
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_READY,
    PH_SETUP,
    PH_STROBE
  } wr_phase_t;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: init_cmd = FUNC_8BIT_2L;
      3'd4:                   init_cmd = DISP_OFF;
      3'd5:                   init_cmd = CLEAR;
      3'd6:                   init_cmd = ENTRY_INC;
      default:                init_cmd = DISP_ON;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// Bus-tick prescaler plus the three-tick EN write cycle; accepts one byte
// per start/done handshake and holds the bus between writes.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int TICK_DIV = 125000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       rs,
  output logic       tick,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  wr_phase_t        phase_q, phase_d;
  logic             en_d, rs_d;
  logic [7:0]       data_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // T0 latches RS/data with EN low, T1 raises EN, T2 drops EN and reports done
  always_comb begin
    phase_d = phase_q;
    en_d    = lcd_en;
    rs_d    = lcd_rs;
    data_d  = lcd_data;
    done    = 1'b0;
    if (tick) begin
      case (phase_q)
        PH_READY: begin
          if (start) begin
            rs_d    = rs;
            data_d  = data;
            en_d    = 1'b0;
            phase_d = PH_SETUP;
          end
        end
        PH_SETUP: begin
          en_d    = 1'b1;
          phase_d = PH_STROBE;
        end
        PH_STROBE: begin
          en_d    = 1'b0;
          done    = 1'b1;
          phase_d = PH_READY;
        end
        default: phase_d = PH_READY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_READY;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      phase_q  <= phase_d;
      lcd_en   <= en_d;
      lcd_rs   <= rs_d;
      lcd_data <= data_d;
    end
  end

endmodule

// File: rtl/lcd_text_driver.sv
// HD44780 text driver: power-up init, then full-frame writes of a
// ROWS x COLS snapshot on request (or continuously with AUTO_REFRESH).
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int ROWS         = 2,
  parameter int COLS         = 16,
  parameter int TICK_DIV     = 125000,
  parameter int PWRUP_TICKS  = 20,
  parameter int CLEAR_TICKS  = 2,
  parameter int AUTO_REFRESH = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ROWS*COLS*8-1:0] line_data,
  input  logic                   update_req,
  output logic                   update_ack,
  output logic                   busy,
  input  logic                   backlight,
  inout  wire  [7:0]             LCD_DATA,
  output logic                   LCD_RW,
  output logic                   LCD_EN,
  output logic                   LCD_RS,
  output logic                   LCD_ON,
  output logic                   LCD_BLON
);

  localparam int NCHAR  = ROWS * COLS;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int WAIT_W = 16;

  lcd_state_t          state_q, state_d;
  logic [1:0]          row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [2:0]          idx_q, idx_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [NCHAR*8-1:0]  frame_q;
  logic                snap, ack_d;
  logic                wr_start, wr_rs, wr_done, tick;
  logic [7:0]          wr_byte, bus_data;

  lcd_bus_writer #(
    .TICK_DIV (TICK_DIV)
  ) u_writer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (wr_start),
    .data     (wr_byte),
    .rs       (wr_rs),
    .tick     (tick),
    .done     (wr_done),
    .lcd_en   (LCD_EN),
    .lcd_rs   (LCD_RS),
    .lcd_data (bus_data)
  );

  assign LCD_DATA = bus_data;
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign busy     = (state_q != IDLE) || (AUTO_REFRESH != 0);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    snap     = 1'b0;
    ack_d    = 1'b0;
    wr_start = 1'b0;
    wr_rs    = 1'b0;
    wr_byte  = 8'h00;
    case (state_q)
      PWRUP: begin
        if (tick) begin
          if (int'(wait_q) + 1 >= PWRUP_TICKS) begin
            state_d = INIT;
            wait_d  = '0;
            idx_d   = 3'd0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      INIT: begin
        wr_start = 1'b1;
        wr_byte  = init_cmd(idx_q);
        if (wr_done) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'(CLEAR_IDX)) begin
            state_d = CLR_WAIT;
            wait_d  = '0;
          end else if (idx_q == 3'(INIT_LEN - 1)) begin
            state_d = IDLE;
          end
        end
      end
      CLR_WAIT: begin
        if (tick) begin
          if (int'(wait_q) + 1 >= CLEAR_TICKS) begin
            state_d = INIT;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      IDLE: begin
        if (AUTO_REFRESH != 0 || update_req) begin
          snap    = 1'b1;
          ack_d   = (AUTO_REFRESH == 0);
          row_d   = 2'd0;
          col_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        wr_start = 1'b1;
        wr_byte  = SET_DDRAM | ROW_BASE[row_q];
        if (wr_done) begin
          col_d   = '0;
          state_d = CHAR;
        end
      end
      CHAR: begin
        wr_start = 1'b1;
        wr_rs    = 1'b1;
        wr_byte  = frame_q[(NCHAR - 1 - (int'(row_q) * COLS + int'(col_q))) * 8 +: 8];
        if (wr_done) begin
          if (col_q == COL_W'(COLS - 1)) begin
            col_d = '0;
            if (row_q == 2'(ROWS - 1)) begin
              state_d = IDLE;
            end else begin
              row_d   = row_q + 2'd1;
              state_d = ADDR;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PWRUP;
      row_q      <= 2'd0;
      col_q      <= '0;
      idx_q      <= 3'd0;
      wait_q     <= '0;
      update_ack <= 1'b0;
      LCD_BLON   <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      update_ack <= ack_d;
      LCD_BLON   <= backlight;
    end
  end

  // Frame snapshot: later line_data changes never reach the frame in flight
  always_ff @(posedge clk) begin
    if (snap) begin
      frame_q <= line_data;
    end
  end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Scoreboard bench: three driver instances (2x16, 4x20, 1x8 auto-refresh)
// with expected bus writes queued by stimulus and popped on EN falling edges.
module tb_lcd_text_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [8:0] q_c[$];

  logic         rst_a, rst_b, rst_c;
  logic [255:0] ld_a;
  logic [639:0] ld_b;
  logic [63:0]  ld_c;
  logic         req_a, req_b, req_c, bl_a;
  logic         ack_a, ack_b, ack_c, busy_a, busy_b, busy_c;
  wire  [7:0]   data_a, data_b, data_c;
  logic         rw_a, rw_b, rw_c, en_a, en_b, en_c, rs_a, rs_b, rs_c;
  logic         on_a, on_b, on_c, blon_a, blon_b, blon_c;

  lcd_text_driver #(.ROWS(2), .COLS(16), .TICK_DIV(4), .PWRUP_TICKS(2),
                    .CLEAR_TICKS(2), .AUTO_REFRESH(0)) dut_a (
    .clk(clk), .rst_n(rst_a), .line_data(ld_a), .update_req(req_a),
    .update_ack(ack_a), .busy(busy_a), .backlight(bl_a), .LCD_DATA(data_a),
    .LCD_RW(rw_a), .LCD_EN(en_a), .LCD_RS(rs_a), .LCD_ON(on_a), .LCD_BLON(blon_a));

  lcd_text_driver #(.ROWS(4), .COLS(20), .TICK_DIV(4), .PWRUP_TICKS(2),
                    .CLEAR_TICKS(2), .AUTO_REFRESH(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .line_data(ld_b), .update_req(req_b),
    .update_ack(ack_b), .busy(busy_b), .backlight(1'b0), .LCD_DATA(data_b),
    .LCD_RW(rw_b), .LCD_EN(en_b), .LCD_RS(rs_b), .LCD_ON(on_b), .LCD_BLON(blon_b));

  lcd_text_driver #(.ROWS(1), .COLS(8), .TICK_DIV(4), .PWRUP_TICKS(2),
                    .CLEAR_TICKS(2), .AUTO_REFRESH(1)) dut_c (
    .clk(clk), .rst_n(rst_c), .line_data(ld_c), .update_req(req_c),
    .update_ack(ack_c), .busy(busy_c), .backlight(1'b0), .LCD_DATA(data_c),
    .LCD_RW(rw_c), .LCD_EN(en_c), .LCD_RS(rs_c), .LCD_ON(on_c), .LCD_BLON(blon_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int qsize(input int w);
    case (w)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic qpush(input int w, input logic [8:0] v);
    case (w)
      0:       q_a.push_back(v);
      1:       q_b.push_back(v);
      default: q_c.push_back(v);
    endcase
  endtask

  task automatic mon_pop(input int w, input logic [8:0] act);
    logic [8:0] exp;
    if (qsize(w) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL bus%0d_extra_write: got %03h expected no write", w, act);
    end else begin
      case (w)
        0:       exp = q_a.pop_front();
        1:       exp = q_b.pop_front();
        default: exp = q_c.pop_front();
      endcase
      check($sformatf("bus%0d_write", w), {23'd0, act}, {23'd0, exp});
    end
  endtask

  logic en_prev_a = 1'b0, en_prev_b = 1'b0, en_prev_c = 1'b0;
  always @(negedge clk) begin
    if (rst_a && en_prev_a && !en_a) mon_pop(0, {rs_a, data_a});
    en_prev_a = rst_a && en_a;
  end
  always @(negedge clk) begin
    if (rst_b && en_prev_b && !en_b) mon_pop(1, {rs_b, data_b});
    en_prev_b = rst_b && en_b;
  end
  always @(negedge clk) begin
    if (rst_c && en_prev_c && !en_c) mon_pop(2, {rs_c, data_c});
    en_prev_c = rst_c && en_c;
  end

  task automatic push_init(input int w);
    qpush(w, 9'h038); qpush(w, 9'h038); qpush(w, 9'h038); qpush(w, 9'h038);
    qpush(w, 9'h008); qpush(w, 9'h001); qpush(w, 9'h006); qpush(w, 9'h00C);
  endtask

  task automatic push_row(input int w, input logic [7:0] addr, input string s);
    qpush(w, {1'b0, addr});
    for (int i = 0; i < s.len(); i++) qpush(w, {1'b1, s[i]});
  endtask

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Waits on negedges until busy equals lvl; returns clocks waited
  task automatic wait_busy(input int w, input logic lvl, input int maxc,
                           input string name, output int k);
    k = 0;
    while (busy_of(w) !== lvl && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, busy_of(w)}, {31'd0, lvl});
  endtask

  task automatic drain(input int w, input int maxc, input string name);
    int k;
    k = 0;
    while (qsize(w) != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(name, qsize(w), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, extra, rises, acks, blow, gmin, gmax, last, t, gap;
    logic prev;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; bl_a = 1'b0;
    ld_a = {"HELLO WORLD     ", "0123456789ABCDEF"};
    ld_b = {"Row zero: ABCDEFGHIJ", "Row one:  KLMNOPQRST",
            "Row two:  UVWXYZ0123", "Row three:456789!@#$"};
    ld_c = "AUTOTEST";
    repeat (3) @(negedge clk);

    check("rst_en", {31'd0, en_a}, 0);
    check("rst_rs", {31'd0, rs_a}, 0);
    check("rst_rw", {31'd0, rw_a}, 0);
    check("rst_data", {24'd0, data_a}, 0);
    check("rst_blon", {31'd0, blon_a}, 0);
    check("rst_busy", {31'd0, busy_a}, 1);
    check("rst_ack", {31'd0, ack_a}, 0);
    check("lcd_on", {31'd0, on_a}, 1);

    // Init sequence on the 2x16 instance
    bl_a = 1'b1;
    push_init(0);
    rst_a = 1'b1;
    wait_busy(0, 1'b0, 2000, "a_init_done", k);
    check_range("a_init_clks", k, 108, 116);
    check("a_blon", {31'd0, blon_a}, 1);
    repeat (60) @(negedge clk);
    check("a_init_drained", qsize(0), 0);
    check("a_idle_busy", {31'd0, busy_a}, 0);

    // Frame 1: single-clock request
    push_row(0, 8'h80, "HELLO WORLD     ");
    push_row(0, 8'hC0, "0123456789ABCDEF");
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    check("a_ack_latency", {31'd0, ack_a}, 1);
    check("a_busy_with_ack", {31'd0, busy_a}, 1);
    k = 0; extra = 0;
    while (busy_a && k < 3000) begin
      @(negedge clk);
      k++;
      if (ack_a) extra++;
    end
    check("a_ack_width_extra", extra, 0);
    check_range("a_frame_clks", k, 405, 408);
    drain(0, 100, "a_frame1_drained");

    // Frame 2: data changed after snapshot; request held through the frame
    push_row(0, 8'h80, "HELLO WORLD     ");
    push_row(0, 8'hC0, "0123456789ABCDEF");
    req_a = 1'b1;
    @(negedge clk);
    check("a_ack2", {31'd0, ack_a}, 1);
    repeat (4) @(negedge clk);
    ld_a = {32{8'h2A}};
    wait_busy(0, 1'b0, 3000, "a_frame2_done", k);
    check("a_no_ack_at_fall", {31'd0, ack_a}, 0);
    @(negedge clk);
    check("a_held_ack", {31'd0, ack_a}, 1);
    req_a = 1'b0;
    push_row(0, 8'h80, "****************");
    push_row(0, 8'hC0, "****************");
    @(negedge clk);
    wait_busy(0, 1'b0, 3000, "a_frame3_done", k);
    drain(0, 100, "a_frame3_drained");

    // Reset during the 5th character's EN-high tick
    ld_a = {"HELLO WORLD     ", "0123456789ABCDEF"};
    qpush(0, 9'h080);
    qpush(0, {1'b1, 8'h48}); qpush(0, {1'b1, 8'h45});
    qpush(0, {1'b1, 8'h4C}); qpush(0, {1'b1, 8'h4C});
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    rises = 0; prev = 1'b0; k = 0;
    while (rises < 6 && k < 3000) begin
      @(negedge clk);
      k++;
      if (en_a && !prev) rises++;
      prev = en_a;
    end
    check("a_fifth_char_reached", rises, 6);
    rst_a = 1'b0;
    #1;
    check("a_en_async_drop", {31'd0, en_a}, 0);
    check("a_busy_in_reset", {31'd0, busy_a}, 1);
    check("a_partial_drained", qsize(0), 0);
    @(negedge clk);
    check("a_data_in_reset", {24'd0, data_a}, 0);
    push_init(0);
    rst_a = 1'b1;
    wait_busy(0, 1'b0, 2000, "a_reinit_done", k);
    check_range("a_reinit_clks", k, 108, 116);
    drain(0, 100, "a_reinit_drained");

    // 4x20 geometry
    push_init(1);
    rst_b = 1'b1;
    wait_busy(1, 1'b0, 2000, "b_init_done", k);
    push_row(1, 8'h80, "Row zero: ABCDEFGHIJ");
    push_row(1, 8'hC0, "Row one:  KLMNOPQRST");
    push_row(1, 8'h94, "Row two:  UVWXYZ0123");
    push_row(1, 8'hD4, "Row three:456789!@#$");
    req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    check("b_ack", {31'd0, ack_b}, 1);
    k = 0;
    while (busy_b && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_range("b_frame_clks", k, 1005, 1008);
    drain(1, 100, "b_frame_drained");

    // Auto-refresh: back-to-back frames, no ack, busy never low
    push_init(2);
    for (int f = 0; f < 3; f++) push_row(2, 8'h80, "AUTOTEST");
    req_c = 1'b1;
    rst_c = 1'b1;
    acks = 0; blow = 0; gmin = 100000; gmax = 0; last = -1; t = 0; prev = 1'b0;
    while (qsize(2) != 0 && t < 4000) begin
      @(negedge clk);
      t++;
      if (ack_c) acks++;
      if (qsize(2) <= 27) begin
        if (!busy_c) blow++;
        if (en_c && !prev) begin
          if (last >= 0) begin
            gap = t - last;
            if (gap < gmin) gmin = gap;
            if (gap > gmax) gmax = gap;
          end
          last = t;
        end
      end
      prev = en_c;
    end
    check("c_drained", qsize(2), 0);
    check("c_ack_never", acks, 0);
    check("c_busy_low_clks", blow, 0);
    check("c_min_write_gap", gmin, 12);
    check("c_max_write_gap", gmax, 12);
    rst_c = 1'b0;
    req_c = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
